// File: rtl/fetch_stage_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: redirect has priority over hold, otherwise step by 4.
module fetch_stage_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic        hold,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (!hold) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, IF/ID register and boot FSM; kills wrong-path work on EX redirect.
// Define FETCH_PERF_EN to add saturating redirect/stall performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        stall,
    input  logic        jump_flag,
    input  logic [31:0] ex_npc,
    input  logic [31:0] irom_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        flush_id_ex
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stalls
`endif
);

    fetch_state_t state;
    logic         redirect;
    logic         hold;
    logic [31:0]  target;

    // EX only carries bubbles during BOOT, so a redirect then is meaningless.
    assign redirect    = (state == RUN) && jump_flag;
    assign hold        = (state == BOOT) || stall;
    assign target      = ex_npc & 32'hFFFF_FFFC;
    assign flush_id_ex = redirect;

    fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (cpu_clk),
        .rst      (cpu_rst),
        .redirect (redirect),
        .hold     (hold),
        .target   (target),
        .pc       (if_pc)
    );

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state       <= BOOT;
            if_id_pc    <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    if_id_pc    <= 32'h0;
                    if_id_pc4   <= 32'h0;
                    if_id_inst  <= NOP_INST;
                    if_id_valid <= 1'b0;
                end
                RUN: begin
                    if (jump_flag) begin
                        if_id_pc    <= 32'h0;
                        if_id_pc4   <= 32'h0;
                        if_id_inst  <= NOP_INST;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        if_id_pc    <= if_pc;
                        if_id_pc4   <= if_pc + 32'd4;
                        if_id_inst  <= irom_inst;
                        if_id_valid <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // A stall that coincides with a redirect is counted only as a redirect.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            perf_redirects <= 32'h0;
            perf_stalls    <= 32'h0;
        end else if (state == RUN) begin
            if (jump_flag && (perf_redirects != 32'hFFFF_FFFF)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (!jump_flag && stall && (perf_stalls != 32'hFFFF_FFFF)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
